conditional_sum_adder_sequencer: RTL and testbench

Multi-cycle WIDTH-bit adder/subtractor controller that owns one 4-bit conditional-sum adder slice. It reuses the slice once per nibble, from LSB to MSB, and carries the inter-nibble carry in a register. It also latches operands behind a valid/ready input handshake and holds the result behind a valid/ready output handshake. It sits between a register-file/ALU front end and any consumer that can trade latency for a single small adder datapath.

---
 rtl/conditional_sum_adder_sequencer.sv | 135 +++++++++++++
 tb/tb_conditional_sum_adder_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/conditional_sum_adder_sequencer.sv
// rtl/conditional_sum_adder_sequencer.sv - nibble-serial WIDTH-bit add/sub sequencer around one 4-bit conditional-sum slice

module conditional_sum_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] s0, s1, c0, c1;
    logic [1:0] p0_sum0, p0_sum1, p1_sum0, p1_sum1;
    logic       p0_c0, p0_c1, p1_c0, p1_c1;
    logic [3:0] sum0, sum1;
    logic       co0, co1;

    // Per-bit sums/carries for both possible carry-ins, merged pairwise then selected by cin.
    assign s0 = a ^ b;
    assign s1 = ~(a ^ b);
    assign c0 = a & b;
    assign c1 = a | b;

    assign p0_sum0 = {(c0[0] ? s1[1] : s0[1]), s0[0]};
    assign p0_c0   = c0[0] ? c1[1] : c0[1];
    assign p0_sum1 = {(c1[0] ? s1[1] : s0[1]), s1[0]};
    assign p0_c1   = c1[0] ? c1[1] : c0[1];

    assign p1_sum0 = {(c0[2] ? s1[3] : s0[3]), s0[2]};
    assign p1_c0   = c0[2] ? c1[3] : c0[3];
    assign p1_sum1 = {(c1[2] ? s1[3] : s0[3]), s1[2]};
    assign p1_c1   = c1[2] ? c1[3] : c0[3];

    assign sum0 = {(p0_c0 ? p1_sum1 : p1_sum0), p0_sum0};
    assign co0  = p0_c0 ? p1_c1 : p1_c0;
    assign sum1 = {(p0_c1 ? p1_sum1 : p1_sum0), p0_sum1};
    assign co1  = p0_c1 ? p1_c1 : p1_c0;

    assign sum  = cin ? sum1 : sum0;
    assign cout = cin ? co1 : co0;
endmodule

module conditional_sum_adder_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C_out,
    output logic             V
);
    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             carry_reg;
    logic [KW-1:0]    k;
    logic [3:0]       nib_a, nib_b, nib_sum;
    logic             nib_cout;

    assign nib_a = a_reg[4*k +: 4];
    assign nib_b = b_reg[4*k +: 4];

    conditional_sum_slice u_slice (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_reg),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)     state_next = RUN;
            RUN:     if (k == K_LAST)  state_next = DONE;
            DONE:    if (out_ready)    state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Subtraction is A + ~B + ~borrow, so the inversions happen once at accept time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            k         <= '0;
            S         <= '0;
            C_out     <= 1'b0;
            V         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_reg     <= A;
                    b_reg     <= sub ? ~B : B;
                    carry_reg <= sub ? ~C_in : C_in;
                    k         <= '0;
                    S         <= '0;
                    C_out     <= 1'b0;
                    V         <= 1'b0;
                end
                RUN: begin
                    S[4*k +: 4] <= nib_sum;
                    carry_reg   <= nib_cout;
                    if (k == K_LAST) begin
                        C_out <= nib_cout;
                        V     <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (nib_sum[3] != a_reg[WIDTH-1]);
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conditional_sum_adder_sequencer.sv
// tb/tb_conditional_sum_adder_sequencer.sv - scoreboard bench for conditional_sum_adder_sequencer

module tb_conditional_sum_adder_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        C_in = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] S;
    logic        C_out;
    logic        V;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q[$];

    conditional_sum_adder_sequencer #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .C_in      (C_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .C_out     (C_out),
        .V         (V)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_in_ready"},  32'(in_ready),  32'd1);
        check({name, "_out_valid"}, 32'(out_valid), 32'd0);
        check({name, "_S"},         32'(S),         32'h0);
        check({name, "_C_out"},     32'(C_out),     32'd0);
        check({name, "_V"},         32'(V),         32'd0);
    endtask

    // Monitor: one comparison per completed output transfer.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            logic [17:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got S=0x%04h C=%0d V=%0d with nothing expected", S, C_out, V);
            end else begin
                e = exp_q.pop_front();
                if ({S, C_out, V} !== e) begin
                    errors++;
                    $display("FAIL result: got S=0x%04h C=%0d V=%0d expected S=0x%04h C=%0d V=%0d",
                             S, C_out, V, e[17:2], e[1], e[0]);
                end
            end
        end
    end

    task automatic drive_accept(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
        int budget;
        A = a; B = b; C_in = ci; sub = sb; in_valid = 1'b1;
        budget = 0;
        while (!in_ready && budget < 20) begin
            @(posedge clk); #1; budget++;
        end
        if (!in_ready) begin
            errors++; checks++;
            $display("FAIL accept_timeout: in_ready stayed 0");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sb,
                          input logic [15:0] es, input logic ec, input logic ev);
        int lat;
        exp_q.push_back({es, ec, ev});
        drive_accept(a, b, ci, sb);
        check({name, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        wait_valid(lat);
        check({name, "_latency"}, 32'(lat), 32'd4);
        @(posedge clk); #1;
        check({name, "_one_cycle_valid"}, 32'(out_valid), 32'd0);
        check({name, "_in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        // Reset during idle
        #1;
        check_idle_outputs("reset_hold");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("reset_release");

        run_op("add_5555",   16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("add_carry",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_bin",    16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);

        // Reset mid-RUN: operation must vanish without a result
        drive_accept(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_idle_outputs("reset_mid_run");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("reset_mid_release");
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("no_stale_valid", 32'(out_valid), 32'd0);
        end

        // Backpressure with ignored requests during RUN/DONE
        out_ready = 1'b0;
        exp_q.push_back({16'h1000, 1'b0, 1'b0});
        drive_accept(16'h00FF, 16'h0F01, 1'b0, 1'b0);
        A = 16'hDEAD; B = 16'hBEEF; C_in = 1'b1; sub = 1'b1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            in_valid = ~in_valid;
            @(posedge clk); #1; lat++;
        end
        check("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_S",         32'(S),         32'h1000);
            check("bp_C_out",     32'(C_out),     32'd0);
            check("bp_V",         32'(V),         32'd0);
        end
        // Release: transfer, then back-to-back accept on the next edge
        A = 16'hA5A5; B = 16'h5A5A; C_in = 1'b1; sub = 1'b0; in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("b2b_in_ready",  32'(in_ready),  32'd1);
        check("b2b_out_valid", 32'(out_valid), 32'd0);
        exp_q.push_back({16'h0000, 1'b1, 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_accepted", 32'(in_ready), 32'd0);
        wait_valid(lat);
        check("b2b_latency", 32'(lat), 32'd4);
        @(posedge clk); #1;
        check("b2b_done", 32'(out_valid), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
